// File: rtl/vec_counter_pkg.sv
// Shared types and helpers for the vector counter bank.
// Optional saturation mode is selected by VEC_COUNTER_SAT_EN in vec_counter_chan.
package vec_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_e;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_counter_chan.sv
// Single counter channel: load > enable priority, terminal wrap (or saturate
// when VEC_COUNTER_SAT_EN is defined) with a one-cycle wrap pulse.
module vec_counter_chan #(
  parameter int unsigned     WIDTH = 32,
  parameter longint unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH:0]   w_sum;
  logic             w_term;
  logic [WIDTH-1:0] w_term_val;

  // Extra carry bit keeps an overflowing sum from looking small.
  assign w_sum  = {1'b0, r_count} + STEP_EXT;
  assign w_term = w_sum > {1'b0, limit};

`ifdef VEC_COUNTER_SAT_EN
  assign w_term_val = limit;
`else
  assign w_term_val = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (load) begin
        r_count <= load_val;
      end else if (en) begin
        if (w_term) begin
          r_count <= w_term_val;
          r_wrap  <= 1'b1;
        end else begin
          r_count <= w_sum[WIDTH-1:0];
        end
      end
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;

endmodule

// File: rtl/vec_counter_bank.sv
// Bank of independent counters with a held single-entry snapshot read port.
// Terminal behaviour follows VEC_COUNTER_SAT_EN (see vec_counter_chan).
module vec_counter_bank
  import vec_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     CHANNELS = 4,
  parameter longint unsigned STEP     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS-1:0]               en,
  input  logic [CHANNELS-1:0]               load,
  input  logic [WIDTH-1:0]                  load_val,
  input  logic [WIDTH-1:0]                  limit,
  output logic [CHANNELS*WIDTH-1:0]         count,
  output logic [CHANNELS-1:0]               wrap,
  input  logic                              rd_req,
  input  logic [ch_w(CHANNELS)-1:0]         rd_sel,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [WIDTH-1:0]                  rd_data
);

  localparam int unsigned CH_W = ch_w(CHANNELS);

  logic [WIDTH-1:0] w_counts [CHANNELS];
  logic [WIDTH-1:0] w_sel_count;
  snap_state_e      r_state;
  snap_state_e      w_next_state;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_next_data;
  logic             r_valid;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    vec_counter_chan #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en[g]),
      .load     (load[g]),
      .load_val (load_val),
      .limit    (limit),
      .count    (w_counts[g]),
      .wrap     (wrap[g])
    );
    assign count[g*WIDTH +: WIDTH] = w_counts[g];
  end

  // Select mux; an out-of-range select matches nothing and yields zero.
  always_comb begin
    w_sel_count = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rd_sel == CH_W'(i)) w_sel_count = w_counts[i];
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_data  = r_data;
    case (r_state)
      IDLE: begin
        if (rd_req) begin
          w_next_state = HOLD;
          w_next_data  = w_sel_count;
        end
      end
      HOLD: begin
        if (rd_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_data  <= w_next_data;
      r_valid <= (w_next_state == HOLD);
    end
  end

  assign rd_valid = r_valid;
  assign rd_data  = r_data;

endmodule
